lvt_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the two write ports of the 4R2W LVT-banked RAM (ram_4R2W) among NREQ write requesters.
- Grants at most two writes per cycle, one per port, and never issues the same address on both ports in one cycle. This keeps the LVT bank selection unambiguous and keeps write order deterministic.
- Drives registered w_addr/w_din/w_enb for both RAM write ports.
- Reports address-conflict stalls through a saturating counter.

---
 rtl/lvt_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_lvt_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lvt_write_arbiter
// Description : Round-robin arbiter sharing the two write ports of a 4R2W
//               LVT-banked RAM among NREQ requesters. Grants up to two
//               writes per cycle with distinct addresses, registers the
//               RAM write ports and counts same-address conflict denials.
// Revision    : 1.0 - initial release
// ============================================================================
module lvt_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        w_addr_1,
    output logic [DATA_W-1:0]        w_din_1,
    output logic                     w_enb_1,
    output logic [ADDR_W-1:0]        w_addr_2,
    output logic [DATA_W-1:0]        w_din_2,
    output logic                     w_enb_2,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int PTR_W = $clog2(NREQ);
    // Conflict count per cycle is at most NREQ-1.
    localparam int NCW   = $clog2(NREQ) + 1;
    localparam int SUM_W = CNT_W + NCW;

    // Registered state
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_enb_1;
    logic              r_enb_2;
    logic [ADDR_W-1:0] r_addr_1;
    logic [ADDR_W-1:0] r_addr_2;
    logic [DATA_W-1:0] r_din_1;
    logic [DATA_W-1:0] r_din_2;

    // Requester fields unpacked into arrays so the scan can index by pointer
    logic [ADDR_W-1:0] w_addr_arr [NREQ];
    logic [DATA_W-1:0] w_data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan results
    logic              w_a_vld;
    logic [PTR_W-1:0]  w_a_idx;
    logic [ADDR_W-1:0] w_a_addr;
    logic              w_b_vld;
    logic [PTR_W-1:0]  w_b_idx;
    logic [NCW-1:0]    w_conf_n;
    logic [NREQ-1:0]   w_ready;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W-1:0]  w_idx;

    // Round-robin scan from r_ptr: first valid is slot A, first later valid
    // with a different address is slot B, same-address laters are denied.
    always_comb begin
        w_a_vld  = 1'b0;
        w_a_idx  = '0;
        w_a_addr = '0;
        w_b_vld  = 1'b0;
        w_b_idx  = '0;
        w_conf_n = '0;
        w_ready  = '0;
        w_sum    = '0;
        w_idx    = '0;
        if (!hold && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
                if (w_sum >= (PTR_W+1)'(NREQ)) begin
                    w_sum = w_sum - (PTR_W+1)'(NREQ);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (req_valid[w_idx]) begin
                    if (!w_a_vld) begin
                        w_a_vld  = 1'b1;
                        w_a_idx  = w_idx;
                        w_a_addr = w_addr_arr[w_idx];
                    end else if (w_addr_arr[w_idx] == w_a_addr) begin
                        w_conf_n = w_conf_n + NCW'(1);
                    end else if (!w_b_vld) begin
                        w_b_vld = 1'b1;
                        w_b_idx = w_idx;
                    end
                end
            end
            if (w_a_vld) w_ready[w_a_idx] = 1'b1;
            if (w_b_vld) w_ready[w_b_idx] = 1'b1;
        end
    end

    // Next pointer: one past the last granted slot, wrapping at NREQ
    logic [PTR_W-1:0] w_last;
    logic [PTR_W:0]   w_nxt_sum;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Pointer advance computation
    always_comb begin
        w_last    = w_b_vld ? w_b_idx : w_a_idx;
        w_nxt_sum = {1'b0, w_last} + (PTR_W+1)'(1);
        if (w_nxt_sum >= (PTR_W+1)'(NREQ)) begin
            w_nxt_sum = '0;
        end
        w_ptr_nxt = w_nxt_sum[PTR_W-1:0];
    end

    // Saturating conflict counter next value
    logic [SUM_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Add this cycle's denials and clamp at the counter's maximum
    always_comb begin
        w_cnt_sum = SUM_W'(r_cnt) + SUM_W'(w_conf_n);
        if (w_cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
            w_cnt_nxt = {CNT_W{1'b1}};
        end else begin
            w_cnt_nxt = w_cnt_sum[CNT_W-1:0];
        end
    end

    // State registers: pointer, counter and the RAM write port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_enb_1  <= 1'b0;
            r_enb_2  <= 1'b0;
            r_addr_1 <= '0;
            r_addr_2 <= '0;
            r_din_1  <= '0;
            r_din_2  <= '0;
        end else begin
            r_enb_1 <= w_a_vld;
            r_enb_2 <= w_b_vld;
            if (w_a_vld) begin
                r_addr_1 <= w_addr_arr[w_a_idx];
                r_din_1  <= w_data_arr[w_a_idx];
                r_ptr    <= w_ptr_nxt;
            end
            if (w_b_vld) begin
                r_addr_2 <= w_addr_arr[w_b_idx];
                r_din_2  <= w_data_arr[w_b_idx];
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign req_ready    = w_ready;
    assign w_enb_1      = r_enb_1;
    assign w_enb_2      = r_enb_2;
    assign w_addr_1     = r_addr_1;
    assign w_addr_2     = r_addr_2;
    assign w_din_1      = r_din_1;
    assign w_din_2      = r_din_2;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lvt_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvt_write_arbiter
// Description : Directed self-checking bench for lvt_write_arbiter
//               (NREQ=4, ADDR_W=12, DATA_W=32, CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvt_write_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hold;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [ADDR_W-1:0]      w_addr_1, w_addr_2;
    logic [DATA_W-1:0]      w_din_1, w_din_2;
    logic                   w_enb_1, w_enb_2;
    logic [CNT_W-1:0]       conflict_cnt;

    logic [ADDR_W-1:0] a [NREQ];
    logic [DATA_W-1:0] d [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = a[i];
            req_data[i*DATA_W +: DATA_W] = d[i];
        end
    end

    lvt_write_arbiter #(
        .NREQ  (NREQ),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hold        (hold),
        .w_addr_1    (w_addr_1),
        .w_din_1     (w_din_1),
        .w_enb_1     (w_enb_1),
        .w_addr_2    (w_addr_2),
        .w_din_2     (w_din_2),
        .w_enb_2     (w_enb_2),
        .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; return on the falling edge, away from the active edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Settle combinational ready after input changes made on the falling edge
    task automatic chk_ready(input string tag, input logic [NREQ-1:0] exp);
        #1;
        chk(tag, 64'(req_ready), 64'(exp));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_distinct();
        for (int i = 0; i < NREQ; i++) begin
            a[i] = ADDR_W'(12'h100 + i);
            d[i] = DATA_W'(32'hA000_0000 + i);
        end
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '1;
        set_distinct();
        @(negedge clk);

        // Reset with all requesters valid
        chk_ready("rst_ready0", 4'b0000);
        step();
        chk("rst_enb1", 64'(w_enb_1), 64'd0);
        chk("rst_enb2", 64'(w_enb_2), 64'd0);
        chk("rst_addr1", 64'(w_addr_1), 64'd0);
        chk("rst_din2", 64'(w_din_2), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        chk_ready("rst_ready1", 4'b0000);
        step();
        rst = 1'b0;
        chk("rel_enb1", 64'(w_enb_1), 64'd0);
        chk("rel_enb2", 64'(w_enb_2), 64'd0);
        chk_ready("rel_first", 4'b0011);
        req_valid = '0;
        step();

        // Single write from requester 2
        req_valid = 4'b0100;
        a[2] = 12'h010;
        d[2] = 32'hDEADBEEF;
        chk_ready("single_rdy", 4'b0100);
        step();
        chk("single_enb1", 64'(w_enb_1), 64'd1);
        chk("single_addr1", 64'(w_addr_1), 64'h010);
        chk("single_din1", 64'(w_din_1), 64'hDEADBEEF);
        chk("single_enb2", 64'(w_enb_2), 64'd0);
        // Pointer now 3: scan 3,0,... grants 3 then 0
        set_distinct();
        req_valid = 4'b1001;
        chk_ready("ptr3_rdy", 4'b1001);
        step();
        chk("ptr3_addr1", 64'(w_addr_1), 64'h103);
        chk("ptr3_addr2", 64'(w_addr_2), 64'h100);
        chk("ptr3_enb2", 64'(w_enb_2), 64'd1);

        // Dual write, distinct addresses, from pointer 0
        do_reset();
        a[0] = 12'h001; d[0] = 32'h1111_0001;
        a[1] = 12'h002; d[1] = 32'h2222_0002;
        req_valid = 4'b0011;
        chk_ready("dual_rdy", 4'b0011);
        step();
        chk("dual_addr1", 64'(w_addr_1), 64'h001);
        chk("dual_din1", 64'(w_din_1), 64'h1111_0001);
        chk("dual_addr2", 64'(w_addr_2), 64'h002);
        chk("dual_din2", 64'(w_din_2), 64'h2222_0002);
        // Pointer now 2: scan 2,3,0 grants 2 then 0
        a[2] = 12'h003; d[2] = 32'h3333_0003;
        req_valid = 4'b0101;
        chk_ready("ptr2_rdy", 4'b0101);
        step();
        chk("ptr2_addr1", 64'(w_addr_1), 64'h003);
        chk("ptr2_addr2", 64'(w_addr_2), 64'h001);

        // Same-address conflict
        do_reset();
        a[0] = 12'h0AA; d[0] = 32'h0000_0011;
        a[1] = 12'h0AA; d[1] = 32'h0000_0022;
        a[2] = 12'h0BB; d[2] = 32'h0000_0033;
        req_valid = 4'b0111;
        chk_ready("conf_rdy1", 4'b0101);
        step();
        chk("conf_addr1", 64'(w_addr_1), 64'h0AA);
        chk("conf_din1", 64'(w_din_1), 64'h11);
        chk("conf_addr2", 64'(w_addr_2), 64'h0BB);
        chk("conf_din2", 64'(w_din_2), 64'h33);
        chk("conf_cnt1", 64'(conflict_cnt), 64'd1);
        req_valid = 4'b0010;
        chk_ready("conf_rdy2", 4'b0010);
        step();
        chk("conf2_enb1", 64'(w_enb_1), 64'd1);
        chk("conf2_addr1", 64'(w_addr_1), 64'h0AA);
        chk("conf2_din1", 64'(w_din_1), 64'h22);
        chk("conf2_enb2", 64'(w_enb_2), 64'd0);
        chk("conf2_cnt", 64'(conflict_cnt), 64'd1);

        // Fairness with all four continuously valid
        do_reset();
        set_distinct();
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            chk_ready($sformatf("fair_rdy%0d", c), (c % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
            chk($sformatf("fair_addr1_%0d", c), 64'(w_addr_1), (c % 2 == 0) ? 64'h100 : 64'h102);
            chk($sformatf("fair_addr2_%0d", c), 64'(w_addr_2), (c % 2 == 0) ? 64'h101 : 64'h103);
        end

        // Hold: nothing granted, pointer frozen at 0
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_ready($sformatf("hold_rdy%0d", c), 4'b0000);
            step();
            chk($sformatf("hold_enb1_%0d", c), 64'(w_enb_1), 64'd0);
            chk($sformatf("hold_enb2_%0d", c), 64'(w_enb_2), 64'd0);
        end
        hold = 1'b0;
        chk_ready("hold_rel_rdy", 4'b0011);

        // Conflicts do not count under hold, then saturate at 3
        do_reset();
        a[0] = 12'h055; a[1] = 12'h055;
        req_valid = 4'b0011;
        hold = 1'b1;
        step();
        chk("hold_cnt", 64'(conflict_cnt), 64'd0);
        hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("sat_cnt%0d", c), 64'(conflict_cnt), (c < 3) ? 64'(c + 1) : 64'd3);
        end

        // Multiple denials in one cycle, then clamp from 2 to 3
        do_reset();
        a[2] = 12'h055;
        req_valid = 4'b0111;
        chk_ready("multi_rdy", 4'b0001);
        step();
        chk("multi_cnt1", 64'(conflict_cnt), 64'd2);
        step();
        chk("multi_cnt2", 64'(conflict_cnt), 64'd3);

        // Reset arriving mid-stream drops the in-flight write
        rst = 1'b1;
        step();
        chk("midrst_enb1", 64'(w_enb_1), 64'd0);
        chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
